// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake and status bundle for fifo_sync_param.
// The FIFO takes the slave side; the producer/consumer logic takes the master side.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with registered status flags, occupancy count,
// sticky overflow/underflow errors and a selectable first-word-fall-through read port.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic               clk,
  input logic               rst_n,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wa;
  logic          ra;

  // Accept decisions use the registered flags, so a write at full is dropped
  // even when a read is accepted on the same edge.
  always_comb begin
    wa = bus.winc & ~full_q;
    ra = bus.rinc & ~empty_q;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wa) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (ra) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    count_d = count_q;
    unique case ({wa, ra})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    overflow_d  = (bus.winc & full_q)  | (overflow_q  & ~bus.clr_err);
    underflow_d = (bus.rinc & empty_q) | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wptr_q] <= bus.wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdata = mem[rptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (ra) begin
          rdata_q <= mem[rptr_q];
        end
      end

      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO share one stimulus
// stream and are compared against a queue-based reference model.
module tb_fifo_sync_param;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic          rinc;
  logic          clr_err;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  assign bus0.winc    = winc;
  assign bus0.wdata   = wdata;
  assign bus0.rinc    = rinc;
  assign bus0.clr_err = clr_err;
  assign bus1.winc    = winc;
  assign bus1.wdata   = wdata;
  assign bus1.rinc    = rinc;
  assign bus1.clr_err = clr_err;

  fifo_sync_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  fifo_sync_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] mRdata;
  bit            mOvf;
  bit            mUnf;
  int            checks = 0;
  int            errors = 0;

  // Status vector layout: {full, empty, almost_full, almost_empty, overflow, underflow, count}
  function automatic logic [10:0] exp_status();
    int n = modelQ.size();
    return {(n == DEPTH), (n == 0), (n >= AF), (n <= AE), mOvf, mUnf, 5'(n)};
  endfunction

  function automatic logic [10:0] std_status();
    return {bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
            bus0.overflow, bus0.underflow, bus0.count};
  endfunction

  function automatic logic [10:0] fwft_status();
    return {bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
            bus1.overflow, bus1.underflow, bus1.count};
  endfunction

  task automatic model_reset();
    modelQ.delete();
    mRdata = '0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, and return at posedge+1.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit wasFull  = (modelQ.size() == DEPTH);
    bit wasEmpty = (modelQ.size() == 0);
    winc    = w;
    wdata   = d;
    rinc    = r;
    clr_err = c;
    if (r && !wasEmpty) mRdata = modelQ.pop_front();
    if (w && !wasFull)  modelQ.push_back(d);
    mOvf = (w && wasFull)  || (mOvf && !c);
    mUnf = (r && wasEmpty) || (mUnf && !c);
    @(posedge clk);
    #1;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
    wdata   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (std_status() !== 11'b010100_00000) begin
      errors++;
      $display("[TB] FAIL reset status std: got %b exp %b", std_status(), 11'b010100_00000);
    end
    checks++;
    if (fwft_status() !== 11'b010100_00000) begin
      errors++;
      $display("[TB] FAIL reset status fwft: got %b exp %b", fwft_status(), 11'b010100_00000);
    end
    checks++;
    if (bus0.rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset rdata: got %h exp 00", bus0.rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (std_status() !== exp_status()) begin
        errors++;
        $display("[TB] FAIL fill status std (word %0d): got %b exp %b", i, std_status(), exp_status());
      end
      checks++;
      if (fwft_status() !== exp_status()) begin
        errors++;
        $display("[TB] FAIL fill status fwft (word %0d): got %b exp %b", i, fwft_status(), exp_status());
      end
      checks++;
      if (bus1.rdata !== 8'h00) begin
        errors++;
        $display("[TB] FAIL fill fwft head: got %h exp 00", bus1.rdata);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus0.rdata !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL drain data std (read %0d): got %h exp %h", i, bus0.rdata, 8'(i));
      end
      checks++;
      if (std_status() !== exp_status()) begin
        errors++;
        $display("[TB] FAIL drain status std (read %0d): got %b exp %b", i, std_status(), exp_status());
      end
      if (modelQ.size() > 0) begin
        checks++;
        if (bus1.rdata !== modelQ[0]) begin
          errors++;
          $display("[TB] FAIL drain fwft head: got %h exp %h", bus1.rdata, modelQ[0]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (bus0.count !== 5'd16 || bus0.overflow !== 1'b1 || bus0.full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow set: got count=%0d ovf=%b full=%b exp 16 1 1",
               bus0.count, bus0.overflow, bus0.full);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus0.overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow sticky: got %b exp 1", bus0.overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus0.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow clear: got %b exp 0", bus0.overflow);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    checks++;
    if (bus0.overflow !== 1'b1 || std_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL overflow set-wins: got ovf=%b status %b exp ovf=1 status %b",
               bus0.overflow, std_status(), exp_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus0.rdata === 8'hAA || bus0.rdata !== mRdata) begin
        errors++;
        $display("[TB] FAIL overflow drain data: got %h exp %h", bus0.rdata, mRdata);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held = mRdata;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus0.underflow !== 1'b1 || bus0.count !== 5'd0 || bus0.rdata !== held) begin
      errors++;
      $display("[TB] FAIL underflow set: got unf=%b count=%0d rdata=%h exp 1 0 %h",
               bus0.underflow, bus0.count, bus0.rdata, held);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus0.underflow !== 1'b0 || std_status() !== exp_status()) begin
      errors++;
      $display("[TB] FAIL underflow clear: got %b exp %b", std_status(), exp_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] k = 8'h10;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, k, 1'b0, 1'b0);
      k++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, k, 1'b1, 1'b0);
      k++;
      checks++;
      if (bus0.count !== 5'd8 || bus0.rdata !== mRdata || bus1.rdata !== modelQ[0]) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got count=%0d rdata=%h head=%h exp 8 %h %h",
                 i, bus0.count, bus0.rdata, bus1.rdata, mRdata, modelQ[0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, k, 1'b0, 1'b0);
      k++;
    end
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++;
    if (bus0.count !== 5'd15 || bus0.overflow !== 1'b1 || bus0.full !== 1'b0 ||
        bus0.rdata !== mRdata) begin
      errors++;
      $display("[TB] FAIL full rd+wr: got count=%0d ovf=%b full=%b rdata=%h exp 15 1 0 %h",
               bus0.count, bus0.overflow, bus0.full, bus0.rdata, mRdata);
    end
    while (modelQ.size() > 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus0.rdata !== mRdata || std_status() !== exp_status()) begin
        errors++;
        $display("[TB] FAIL back_to_back drain: got %h/%b exp %h/%b",
                 bus0.rdata, std_status(), mRdata, exp_status());
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (bus1.rdata !== 8'h5A || bus1.empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwft fall-through: got rdata=%h empty=%b exp 5a 0", bus1.rdata, bus1.empty);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus1.empty !== 1'b1 || bus0.rdata !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL fwft pop: got empty=%b std rdata=%h exp 1 5a", bus1.empty, bus0.rdata);
    end
  endtask

  task automatic test_random();
    int pw;
    int pr;
    for (int i = 0; i < 600; i++) begin
      case (i / 150)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 95; pr = 60; end
        default: begin pw = 50; pr = 50; end
      endcase
      step(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 19) == 0));
      checks++;
      if (std_status() !== exp_status() || fwft_status() !== exp_status()) begin
        errors++;
        $display("[TB] FAIL random status cycle %0d: got std %b fwft %b exp %b",
                 i, std_status(), fwft_status(), exp_status());
      end
      checks++;
      if (bus0.rdata !== mRdata) begin
        errors++;
        $display("[TB] FAIL random rdata cycle %0d: got %h exp %h", i, bus0.rdata, mRdata);
      end
      if (modelQ.size() > 0) begin
        checks++;
        if (bus1.rdata !== modelQ[0]) begin
          errors++;
          $display("[TB] FAIL random fwft head cycle %0d: got %h exp %h", i, bus1.rdata, modelQ[0]);
        end
      end
    end
    while (modelQ.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++;
    if (bus0.count !== 5'd9) begin
      errors++;
      $display("[TB] FAIL pre-reset count: got %0d exp 9", bus0.count);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (std_status() !== 11'b010100_00000 || bus0.rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async reset std: got %b rdata=%h exp %b rdata=00",
               std_status(), bus0.rdata, 11'b010100_00000);
    end
    checks++;
    if (fwft_status() !== 11'b010100_00000) begin
      errors++;
      $display("[TB] FAIL async reset fwft: got %b exp %b", fwft_status(), 11'b010100_00000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    checks++;
    if (bus0.count !== 5'd1 || bus1.rdata !== 8'h33) begin
      errors++;
      $display("[TB] FAIL post-reset write: got count=%0d head=%h exp 1 33", bus0.count, bus1.rdata);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus0.rdata !== 8'h33 || bus0.empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post-reset read: got rdata=%h empty=%b exp 33 1", bus0.rdata, bus0.empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised FIFO: the next generation of the team's FIFO line. It generalises data width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in one clock domain, for example as a rate-smoothing buffer ahead of a clock-domain crossing.

## Interface
- DATA_WIDTH, 8: data word width in bits, >=1.
- DEPTH, 16: number of entries; power of two, >=2. AW = log2(DEPTH).
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data, sampled with winc.
- rinc  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. Write and read pointers are AW bits wide and wrap modulo DEPTH.
- Write accept (wa) = winc & !full. When wa: mem[wptr] <= wdata and wptr advances. A write while full is dropped, leaves memory and wptr unchanged, and sets overflow.
- Read accept (ra) = rinc & !empty. When ra, rptr advances. A read while empty is ignored and sets underflow.
- full and empty are evaluated from the count before the edge. A write while full is therefore dropped even if a read is accepted in the same cycle.
- Count update: +1 on wa only, -1 on ra only, unchanged on both or neither.
- All status flags (full, empty, almost_*) are registered and consistent with count after every edge.
- Standard mode (FWFT=0): on ra, rdata <= mem[rptr] and is valid after that edge. rdata holds its value otherwise.
- FWFT mode (FWFT=1): rdata = mem[rptr] continuously. The head word is valid whenever empty=0, and ra pops it. rdata is don't-care while empty.
- Error flags: set on the offending attempt and held until clr_err. If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-burst): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0 (standard mode). FIFO contents are logically discarded.

## Timing
- Write at edge k: count, empty and almost_* reflect it after edge k. A read is acceptable at edge k+1.
- Write-to-read latency, standard mode: rdata is valid after edge k+1 when rinc is held from k+1.
- Write-to-read latency, FWFT mode: rdata is valid after edge k.
- Read-to-data latency, standard mode: 1 cycle.
- Throughput: one write and one read per cycle, sustained at any occupancy 1..DEPTH-1.
- Full: asserts after the edge that accepts the DEPTH-th word. Deasserts after the first ra edge.
- Empty: asserts after the edge of the last ra with no concurrent wa.
- Pointer wrap (DEPTH-1 -> 0) has no bubble and no flag glitch.
- Reset release: the first write is accepted on the first rising edge where rst_n=1 and winc=1.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2 unless stated.
- Fill/drain: write 0x00..0x0F, then read 16 -> full after the 16th write and almost_full at count 14. Data returns 0x00..0x0F in order, empty after the 16th read, almost_empty at count <=2.
- Overflow: at full, issue winc with 0xAA and no rinc -> count stays 16, 0xAA is never read, overflow=1 until clr_err pulses. Repeat with winc and clr_err in the same cycle -> overflow stays 1.
- Underflow: from empty, pulse rinc -> count 0, rdata unchanged, underflow=1. clr_err -> 0.
- Simultaneous: at count 8, hold winc=rinc=1 for 40 cycles with incrementing data -> count constant at 8 and order preserved across pointer wraps. At count 16, winc+rinc -> the read is accepted, the write is dropped, overflow=1 and count=15.
- FWFT=1: write 0x5A into an empty FIFO -> rdata=0x5A and empty=0 after that same edge. Pulse rinc -> empty=1.
- Reset mid-operation: assert rst_n=0 asynchronously between edges at count 9 -> all outputs go immediately to their reset values. After release, write 0x33 then read -> 0x33 is returned.
